// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the multi-channel LED controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARG1,
    ST_ARG2,
    ST_RESP
  } parse_state_t;

  localparam logic [1:0] OP_SET_MODE   = 2'b00;
  localparam logic [1:0] OP_SET_PERIOD = 2'b01;
  localparam logic [1:0] OP_SET_DUTY   = 2'b10;
  localparam logic [1:0] OP_QUERY      = 2'b11;

  localparam logic [7:0] QUERY_BAD = 8'hFF;
  localparam logic [7:0] DEF_DUTY  = 8'h80;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/period/duty registers, blink counter and the
// registered LED drive.
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int PERIOD_W   = 16,
  parameter int DEF_PERIOD = 500,
  parameter bit HEARTBEAT  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [7:0]          pwm_cnt,
  input  logic                wr_mode,
  input  logic                wr_period,
  input  logic                wr_duty,
  input  mode_t               mode_wdata,
  input  logic [PERIOD_W-1:0] period_wdata,
  input  logic [7:0]          duty_wdata,
  output mode_t               mode,
  output logic                led
);

  localparam mode_t RESET_MODE = HEARTBEAT ? MODE_BLINK : MODE_OFF;

  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] blink_cnt;
  logic [PERIOD_W-1:0] blink_last;
  logic [7:0]          duty;
  mode_t               next_mode;
  logic [7:0]          next_duty;
  logic                blink_wrap;
  logic                cfg_write;

  // NOTE: every variable assigned here gets a value on every path, so no latch.
  always_comb begin
    next_mode  = wr_mode ? mode_wdata : mode;
    next_duty  = wr_duty ? duty_wdata : duty;
    cfg_write  = wr_mode || wr_period;
    // A period of 0 counts like a period of 1.
    blink_last = (period == '0) ? '0 : period - PERIOD_W'(1);
    blink_wrap = tick && (blink_cnt == blink_last);
  end

  // NOTE: sequential state uses <= so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode      <= RESET_MODE;
      period    <= PERIOD_W'(DEF_PERIOD);
      duty      <= DEF_DUTY;
      blink_cnt <= '0;
      led       <= 1'b0;
    end else begin
      mode <= next_mode;
      duty <= next_duty;
      if (wr_period) period <= period_wdata;

      // A config write on a tick cycle wins over the blink count.
      if (cfg_write)
        blink_cnt <= '0;
      else if (mode == MODE_BLINK && tick)
        blink_cnt <= blink_wrap ? '0 : blink_cnt + PERIOD_W'(1);

      case (next_mode)
        MODE_OFF:   led <= 1'b0;
        MODE_ON:    led <= 1'b1;
        MODE_PWM:   led <= (pwm_cnt < next_duty);
        MODE_BLINK: begin
          if (wr_mode && mode != MODE_BLINK)
            led <= 1'b0;
          else if (!cfg_write && blink_wrap)
            led <= ~led;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED controller configured through a valid/ready byte stream;
// channel 0 blinks out of reset as the board heartbeat.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 48_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int NUM_CH      = 4,
  parameter int PERIOD_W    = 16,
  parameter int DEF_PERIOD  = 500
) (
  input  logic              clk_48mhz,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NUM_CH-1:0] led
);

  localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (CLK_FREQ_HZ % TICK_HZ != 0) begin : g_bad_tick_div
    $error("led_ctrl: CLK_FREQ_HZ must be divisible by TICK_HZ");
  end
  if (NUM_CH < 1 || NUM_CH > 64 || PERIOD_W < 1 || PERIOD_W > 16) begin : g_bad_range
    $error("led_ctrl: NUM_CH must be 1..64 and PERIOD_W 1..16");
  end

  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic [7:0]         pwm_cnt;

  parse_state_t       state;
  logic [1:0]         cmd_op;
  logic [5:0]         cmd_ch;
  logic [7:0]         arg_hi;
  logic               in_hs;
  logic               wr_fire;
  logic [7:0]         query_byte;
  logic [15:0]        period_word;
  mode_t              ch_mode [NUM_CH];

  assign tick = (presc == PRESC_W'(TICK_DIV - 1));

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= tick ? '0 : presc + PRESC_W'(1);
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  assign in_ready    = !reset && (state != ST_RESP);
  assign in_hs       = in_valid && in_ready;
  // The final argument byte of a SET command is the write strobe.
  assign wr_fire     = in_hs && ((state == ST_ARG1 && cmd_op != OP_SET_PERIOD) ||
                                 state == ST_ARG2);
  assign period_word = {arg_hi, in_data};

  // Status of the channel addressed by the byte currently on in_data.
  always_comb begin
    query_byte = QUERY_BAD;
    for (int n = 0; n < NUM_CH; n++) begin
      if (in_data[5:0] == 6'(n)) query_byte = {ch_mode[n], 5'b0, led[n]};
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_op    <= OP_SET_MODE;
      cmd_ch    <= '0;
      arg_hi    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_hs) begin
            cmd_op <= in_data[7:6];
            cmd_ch <= in_data[5:0];
            if (in_data[7:6] == OP_QUERY) begin
              out_data  <= query_byte;
              out_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              state <= ST_ARG1;
            end
          end
        end
        ST_ARG1: begin
          if (in_hs) begin
            arg_hi <= in_data;
            state  <= (cmd_op == OP_SET_PERIOD) ? ST_ARG2 : ST_IDLE;
          end
        end
        ST_ARG2: begin
          if (in_hs) state <= ST_IDLE;
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic sel;
    assign sel = wr_fire && (cmd_ch == 6'(n));

    led_channel #(
      .PERIOD_W   (PERIOD_W),
      .DEF_PERIOD (DEF_PERIOD),
      .HEARTBEAT  (n == 0)
    ) u_ch (
      .clk          (clk_48mhz),
      .reset        (reset),
      .tick         (tick),
      .pwm_cnt      (pwm_cnt),
      .wr_mode      (sel && cmd_op == OP_SET_MODE),
      .wr_period    (sel && cmd_op == OP_SET_PERIOD),
      .wr_duty      (sel && cmd_op == OP_SET_DUTY),
      .mode_wdata   (mode_t'(in_data[1:0])),
      .period_wdata (period_word[PERIOD_W-1:0]),
      .duty_wdata   (in_data),
      .mode         (ch_mode[n]),
      .led          (led[n])
    );
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: directed sequences, a constant vector
// table and a randomized command stream against a cycle-level reference model.
module tb_led_ctrl;

  localparam int NCH  = 4;
  localparam int DIV  = 10;
  localparam int DEFP = 3;

  logic           clk;
  logic           reset;
  logic [7:0]     in_data;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_ready;
  logic [NCH-1:0] led;

  led_ctrl #(
    .CLK_FREQ_HZ (100),
    .TICK_HZ     (10),
    .NUM_CH      (NCH),
    .PERIOD_W    (16),
    .DEF_PERIOD  (DEFP)
  ) dut (
    .clk_48mhz (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit rand_ready = 1'b0;

  // Reference model: time since reset, per-channel settings, ticks elapsed
  // since the last blink toggle, and the bytes of the command being collected.
  int             t;
  logic [1:0]     m_mode    [NCH];
  int             m_period  [NCH];
  int             m_duty    [NCH];
  int             m_elapsed [NCH];
  logic [NCH-1:0] m_led;
  bit             m_pend;
  logic [7:0]     m_resp;
  bit             m_accepted;
  logic [7:0]     q [$];

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         len;
    logic [7:0] qcmd;
    logic [7:0] qexp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    t      = 0;
    m_led  = '0;
    m_pend = 1'b0;
    m_resp = 8'h00;
    q.delete();
    for (int n = 0; n < NCH; n++) begin
      m_mode[n]    = (n == 0) ? 2'd2 : 2'd0;
      m_period[n]  = DEFP;
      m_duty[n]    = 128;
      m_elapsed[n] = 0;
    end
  endtask

  // Advance the model across one rising edge using the inputs of this cycle.
  task automatic model_edge();
    bit         tick;
    int         pwm;
    int         wtype [NCH];
    int         wval  [NCH];
    logic [1:0] op;
    int         ch;
    int         need;
    logic [1:0] old_mode;
    int         lim;
    m_accepted = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    tick = (t % DIV) == DIV - 1;
    pwm  = t % 256;
    for (int n = 0; n < NCH; n++) begin
      wtype[n] = -1;
      wval[n]  = 0;
    end
    if (m_pend) begin
      if (out_ready) m_pend = 1'b0;
    end else if (in_valid) begin
      m_accepted = 1'b1;
      q.push_back(in_data);
      op   = q[0][7:6];
      ch   = int'(q[0][5:0]);
      need = (op == 2'd3) ? 1 : (op == 2'd1) ? 3 : 2;
      if (q.size() == need) begin
        if (op == 2'd3)
          begin
            m_pend = 1'b1;
            m_resp = (ch < NCH) ? {m_mode[ch], 5'b0, m_led[ch]} : 8'hFF;
          end
        else if (ch < NCH) begin
          wtype[ch] = int'(op);
          wval[ch]  = (op == 2'd1) ? int'({q[1], q[2]}) : int'(q[1]);
        end
        q.delete();
      end
    end
    for (int n = 0; n < NCH; n++) begin
      old_mode = m_mode[n];
      case (wtype[n])
        0: begin m_mode[n] = 2'(wval[n] & 3); m_elapsed[n] = 0; end
        1: begin m_period[n] = wval[n]; m_elapsed[n] = 0; end
        2: m_duty[n] = wval[n];
        default: ;
      endcase
      case (m_mode[n])
        2'd0: m_led[n] = 1'b0;
        2'd1: m_led[n] = 1'b1;
        2'd3: m_led[n] = (pwm < m_duty[n]);
        default: begin
          if (wtype[n] == 0 && old_mode != 2'd2) m_led[n] = 1'b0;
          else if (wtype[n] == 0 || wtype[n] == 1) ;
          else if (tick) begin
            m_elapsed[n]++;
            lim = (m_period[n] == 0) ? 1 : m_period[n];
            if (m_elapsed[n] >= lim) begin
              m_led[n]     = ~m_led[n];
              m_elapsed[n] = 0;
            end
          end
        end
      endcase
    end
    t++;
  endtask

  // Check the current cycle, then move to just after the next rising edge.
  task automatic cycle();
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    #1;
    check("led", 32'(led), 32'(m_led));
    check("in_ready", 32'(in_ready), 32'(!reset && !m_pend));
    check("out_valid", 32'(out_valid), 32'(m_pend));
    if (m_pend) check("out_data", 32'(out_data), 32'(m_resp));
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      cycle();
      n++;
    end while (!m_accepted && n < 200);
    if (!m_accepted) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: byte 0x%0h not accepted within %0d cycles", b, n);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_change(input int ch, input int budget, output int n);
    logic prev;
    prev = led[ch];
    n    = 0;
    while (led[ch] === prev && n < budget) begin
      cycle();
      n++;
    end
  endtask

  task automatic count_high(input int ch, output int c);
    c = 0;
    repeat (256) begin
      c += int'(led[ch]);
      cycle();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         c;
    logic [7:0] exp_q;

    vecs[0]  = '{8'h01, 8'h01, 8'h00, 2, 8'hC1, 8'h41};
    vecs[1]  = '{8'h02, 8'h00, 8'h00, 2, 8'hC2, 8'h00};
    vecs[2]  = '{8'h83, 8'h00, 8'h00, 2, 8'hC3, 8'h41};
    vecs[3]  = '{8'h03, 8'hFF, 8'h00, 2, 8'hC3, 8'hC0};
    vecs[4]  = '{8'h3F, 8'h01, 8'h00, 2, 8'hFF, 8'hFF};
    vecs[5]  = '{8'h04, 8'h01, 8'h00, 2, 8'hC4, 8'hFF};
    vecs[6]  = '{8'h43, 8'h12, 8'h34, 3, 8'hC3, 8'hC0};
    vecs[7]  = '{8'h01, 8'hFD, 8'h00, 2, 8'hC1, 8'h41};
    vecs[8]  = '{8'h81, 8'h10, 8'h00, 2, 8'hC1, 8'h41};
    vecs[9]  = '{8'h01, 8'h00, 8'h00, 2, 8'hC1, 8'h00};
    vecs[10] = '{8'h02, 8'h02, 8'h00, 2, 8'hC2, 8'h80};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset held, then released: idle outputs and the heartbeat.
    repeat (5) cycle();
    reset = 1'b0;
    #1;
    check("rst_led", 32'(led), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    wait_change(0, 100, n);
    check("hb_first_toggle", 32'(n), 32'd30);
    wait_change(0, 100, n);
    check("hb_second_toggle", 32'(n), 32'd30);
    check("hb_other_leds", 32'(led[3:1]), 32'h0);

    // Channel 1: period 2, then BLINK.
    send_byte(8'h41); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02);
    wait_change(1, 100, n);
    check("blink1_first_in_window", 32'(n >= 11 && n <= 20), 32'h1);
    wait_change(1, 100, n);
    check("blink1_interval", 32'(n), 32'd20);

    // Channel 2 PWM at three duty values.
    send_byte(8'h82); send_byte(8'h40);
    send_byte(8'h02); send_byte(8'h03);
    count_high(2, c);
    check("pwm_duty_40", 32'(c), 32'd64);
    send_byte(8'h82); send_byte(8'h00);
    count_high(2, c);
    check("pwm_duty_00", 32'(c), 32'd0);
    send_byte(8'h82); send_byte(8'hFF);
    count_high(2, c);
    check("pwm_duty_ff", 32'(c), 32'd255);

    // Query held off by out_ready.
    send_byte(8'h01); send_byte(8'h02);
    out_ready = 1'b0;
    exp_q = {2'b10, 5'b0, m_led[1]};
    send_byte(8'hC1);
    repeat (5) begin
      check("hold_out_valid", 32'(out_valid), 32'h1);
      check("hold_out_data", 32'(out_data), 32'(exp_q));
      check("hold_in_ready", 32'(in_ready), 32'h0);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    check("drain_out_valid", 32'(out_valid), 32'h0);
    check("drain_in_ready", 32'(in_ready), 32'h1);

    // Invalid channel: SET swallowed, QUERY answers 0xFF.
    send_byte(8'h3F); send_byte(8'h03);
    send_byte(8'hFF);
    check("bad_ch_query", 32'(out_data), 32'hFF);
    cycle();

    // Reset in the middle of a SET_PERIOD command.
    send_byte(8'h40);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    send_byte(8'h03); send_byte(8'h01);
    check("mid_cmd_reset_led3", 32'(led[3]), 32'h1);

    // Vector table: one command, then a query of the affected channel.
    for (int i = 0; i < 11; i++) begin
      send_byte(vecs[i].b0);
      if (vecs[i].len > 1) send_byte(vecs[i].b1);
      if (vecs[i].len > 2) send_byte(vecs[i].b2);
      send_byte(vecs[i].qcmd);
      check($sformatf("vec%0d_resp_valid", i), 32'(out_valid), 32'h1);
      check($sformatf("vec%0d_resp", i), 32'(out_data), 32'(vecs[i].qexp));
      cycle();
    end

    // Randomized command stream with back-pressure on responses.
    rand_ready = 1'b1;
    for (int k = 0; k < 250; k++) begin
      logic [1:0] op;
      logic [5:0] ch;
      logic [7:0] b [3];
      int         len;
      op   = 2'($urandom_range(0, 3));
      ch   = 6'($urandom_range(0, 5));
      b[0] = {op, ch};
      b[1] = 8'($urandom);
      b[2] = 8'h00;
      len  = 2;
      if (op == 2'd1) begin
        b[1] = 8'h00;
        b[2] = 8'($urandom_range(0, 4));
        len  = 3;
      end else if (op == 2'd3) begin
        len = 1;
      end
      if (k == 100) begin
        reset = 1'b1;
        cycle();
        reset = 1'b0;
      end
      for (int j = 0; j < len; j++) begin
        repeat ($urandom_range(0, 2)) cycle();
        send_byte(b[j]);
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (40) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
